// File: rtl/step_clk_gen_pkg.sv
// Shared types and defaults for the manual single-step clock source.
// Board builds override the defaults from define.v (DEBOUNCE_MAX, STEP_PULSE_CYCLES).
// The helper gives a counter width that stays legal when a count of 1 is requested.
package step_clk_gen_pkg;

  localparam int DEBOUNCE_MAX_DEF      = 20;
  localparam int STEP_PULSE_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } step_state_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_clk_gen_btn_debounce.sv
// Two-flop synchroniser plus debounce counter for a raw push-button.
// Latency: a steady new level appears on btn_stable DEBOUNCE_CYCLES+2 edges after it is first sampled.
// Disagreements shorter than DEBOUNCE_CYCLES consecutive cycles never reach btn_stable.
module step_clk_gen_btn_debounce
  import step_clk_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_MAX_DEF
) (
  input  logic out_clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_stable
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [DW-1:0] db_cnt;

  // Bring the asynchronous button into the out_clk domain.
  always_ff @(posedge out_clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Accept a new level only after it has disagreed with btn_stable for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge out_clk or posedge reset) begin
    if (reset) begin
      db_cnt     <= '0;
      btn_stable <= 1'b0;
    end else if (s2 == btn_stable) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_LAST) begin
      db_cnt     <= '0;
      btn_stable <= s2;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/step_clk_gen.sv
// Manual single-step clock: one fixed-width step_clk pulse per debounced, enabled press.
// Latency: step_clk and step_count update DEBOUNCE_CYCLES+3 edges after the press is first sampled.
// No backpressure; a held button never retriggers, a press with step_en low is dropped.
module step_clk_gen
  import step_clk_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_MAX_DEF,
  parameter int PULSE_CYCLES    = STEP_PULSE_CYCLES_DEF,
  parameter int CNT_W           = 16
) (
  input  logic             out_clk,
  input  logic             reset,
  input  logic             btn_in,
  input  logic             step_en,
  output logic             step_clk,
  output logic             step_busy,
  output logic             btn_stable,
  output logic [CNT_W-1:0] step_count
);

  localparam int PW = cnt_width(PULSE_CYCLES);
  localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);

  step_state_t      state;
  step_state_t      state_nxt;
  logic [PW-1:0]    pulse_cnt;
  logic [PW-1:0]    pulse_cnt_nxt;
  logic             step_clk_nxt;
  logic [CNT_W-1:0] step_count_nxt;
  logic             btn_stable_q;
  logic             rise;

  step_clk_gen_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .out_clk   (out_clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .btn_stable(btn_stable)
  );

  // Delay the debounced level by one cycle for rising-edge detection.
  always_ff @(posedge out_clk or posedge reset) begin
    if (reset) btn_stable_q <= 1'b0;
    else       btn_stable_q <= btn_stable;
  end

  assign rise      = btn_stable & ~btn_stable_q;
  assign step_busy = (state != IDLE);

  // State, pulse timer, step clock and press counter; step_clk is a flop so it
  // cannot glitch, and it drops as soon as reset asserts.
  always_ff @(posedge out_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pulse_cnt  <= '0;
      step_clk   <= 1'b0;
      step_count <= '0;
    end else begin
      state      <= state_nxt;
      pulse_cnt  <= pulse_cnt_nxt;
      step_clk   <= step_clk_nxt;
      step_count <= step_count_nxt;
    end
  end

  // Next-state logic: fresh enabled press -> fixed pulse -> wait for release.
  always_comb begin
    state_nxt      = state;
    pulse_cnt_nxt  = pulse_cnt;
    step_clk_nxt   = step_clk;
    step_count_nxt = step_count;
    case (state)
      IDLE: begin
        step_clk_nxt = 1'b0;
        if (rise && step_en) begin
          state_nxt      = PULSE;
          pulse_cnt_nxt  = PULSE_LOAD;
          step_clk_nxt   = 1'b1;
          step_count_nxt = step_count + CNT_W'(1);
        end
      end
      PULSE: begin
        // Neither step_en nor the button level can shorten the pulse.
        if (pulse_cnt == '0) begin
          state_nxt    = WAIT_REL;
          step_clk_nxt = 1'b0;
        end else begin
          pulse_cnt_nxt = pulse_cnt - PW'(1);
          step_clk_nxt  = 1'b1;
        end
      end
      WAIT_REL: begin
        step_clk_nxt = 1'b0;
        if (!btn_stable) state_nxt = IDLE;
      end
      default: begin
        state_nxt    = IDLE;
        step_clk_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_step_clk_gen.sv
// Directed bench for step_clk_gen with DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, CNT_W=2.
// Stimulus pushes the expected pulse (start edge, width, step_count) into a queue;
// a forked monitor measures every step_clk pulse and compares against the queue head.
module tb_step_clk_gen;

  localparam int D = 4;
  localparam int P = 3;

  typedef struct {
    int start;
    int width;
    int count;
  } pulse_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_in = 1'b0;
  logic       step_en = 1'b0;
  logic       step_clk;
  logic       step_busy;
  logic       btn_stable;
  logic [1:0] step_count;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_cnt = 2'd0;
  pulse_t     exp_q[$];

  step_clk_gen #(
    .DEBOUNCE_CYCLES(D),
    .PULSE_CYCLES   (P),
    .CNT_W          (2)
  ) dut (
    .out_clk   (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .step_en   (step_en),
    .step_clk  (step_clk),
    .step_busy (step_busy),
    .btn_stable(btn_stable),
    .step_count(step_count)
  );

  initial forever #5 clk = ~clk;

  // Edge number of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance n rising edges and park 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press is first sampled at the next edge, so the pulse starts D+3 edges later.
  task automatic expect_pulse(input int width);
    pulse_t p;
    exp_cnt = exp_cnt + 2'd1;
    p.start = cyc + D + 3;
    p.width = width;
    p.count = int'(exp_cnt);
    exp_q.push_back(p);
  endtask

  task automatic clean_press(input int hold);
    btn_in = 1'b1;
    expect_pulse(P);
    tick(hold);
    btn_in = 1'b0;
    tick(12);
  endtask

  // Measure each pulse on the falling clock edge and compare with the queue head.
  task automatic monitor();
    logic   prev;
    int     st;
    int     w;
    int     c;
    pulse_t e;
    prev = 1'b0;
    st = 0;
    w = 0;
    c = 0;
    forever begin
      @(negedge clk);
      if (step_clk && !prev) begin
        st = cyc;
        w  = 1;
        c  = int'(step_count);
      end else if (step_clk) begin
        w++;
      end else if (prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_start", st, -1);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_start_edge", st, e.start);
          chk("pulse_width", w, e.width);
          chk("pulse_step_count", c, e.count);
        end
      end
      prev = step_clk;
    end
  endtask

  initial begin
    int n;
    fork
      monitor();
    join_none

    // Reset state.
    #1;
    chk("rst_step_clk", int'(step_clk), 0);
    chk("rst_step_busy", int'(step_busy), 0);
    chk("rst_btn_stable", int'(btn_stable), 0);
    chk("rst_step_count", int'(step_count), 0);
    tick(3);
    reset = 1'b0;
    tick(3);

    // Clean press held for 20 cycles.
    step_en = 1'b1;
    n = cyc;
    btn_in = 1'b1;
    expect_pulse(P);
    tick(D + 1);
    chk("clean_stable_before", int'(btn_stable), 0);
    tick(1);
    chk("clean_stable_after", int'(btn_stable), 1);
    tick(4);
    chk("clean_busy_held", int'(step_busy), 1);
    tick(n + 20 - cyc);
    btn_in = 1'b0;
    tick(D + 2);
    chk("release_stable_low", int'(btn_stable), 0);
    chk("release_busy_still", int'(step_busy), 1);
    tick(1);
    chk("release_busy_idle", int'(step_busy), 0);
    tick(5);

    // Bouncing press: toggles every 2 cycles for 12 cycles, then steady high.
    for (int i = 0; i < 12; i++) begin
      btn_in = ((i / 2) % 2) == 0;
      tick(1);
    end
    clean_press(15);

    // Glitch shorter than the debounce window.
    btn_in = 1'b1;
    tick(3);
    btn_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_stable", int'(btn_stable), 0);
    end
    chk("glitch_count", int'(step_count), int'(exp_cnt));

    // Gating: press with step_en low, then raise step_en while still held.
    step_en = 1'b0;
    btn_in = 1'b1;
    tick(10);
    chk("gate_stable", int'(btn_stable), 1);
    step_en = 1'b1;
    tick(10);
    chk("gate_busy", int'(step_busy), 0);
    chk("gate_count", int'(step_count), int'(exp_cnt));
    btn_in = 1'b0;
    tick(10);
    clean_press(12);

    // Wrap: restart from 0, five presses give counts 1,2,3,0,1.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_cnt = 2'd0;
    tick(2);
    for (int i = 0; i < 5; i++) clean_press(12);
    chk("wrap_count", int'(step_count), 1);

    // Reset during the second high cycle of step_clk, button kept held.
    btn_in = 1'b1;
    expect_pulse(2);
    tick(D + 4);
    #6;
    reset = 1'b1;
    #1;
    chk("midrst_step_clk", int'(step_clk), 0);
    chk("midrst_step_count", int'(step_count), 0);
    chk("midrst_step_busy", int'(step_busy), 0);
    tick(2);
    reset = 1'b0;
    exp_cnt = 2'd0;
    expect_pulse(P);
    tick(15);
    btn_in = 1'b0;
    tick(15);

    chk("missing_pulses", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got edge %0d, expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/step_clk_gen.md
Name: step_clk_gen

Overview:
- Manual single-step clock source for the single-cycle CPU on the board; the manual counterpart to the free-running divided clock.
- Takes a raw, bouncing push-button and synchronises and debounces it.
- Each accepted press produces exactly one fixed-width high pulse on step_clk, for the CPU to run one instruction per press.
- Keeps a step counter for the seven-segment display.

Parameters:
- DEBOUNCE_CYCLES, default 20: consecutive out_clk cycles a changed, synchronised level must hold before it is accepted. Legal range is 1 or more. Board builds override it with `DEBOUNCE_MAX from define.v.
- PULSE_CYCLES, default 4: out_clk cycles step_clk stays high per accepted press. Legal range is 1 or more.
- CNT_W, default 16: width of step_count.

Ports:
- out_clk  in  1  board clock; the only clock in the block.
- reset  in  1  asynchronous, active-high reset.
- btn_in  in  1  raw push-button, asynchronous to out_clk, may bounce.
- step_en  in  1  enables step generation; sampled only on a press edge.
- step_clk  out  1  registered single-step clock pulse.
- step_busy  out  1  high whenever the FSM is not in IDLE.
- btn_stable  out  1  debounced button level.
- step_count  out  CNT_W  number of pulses issued; wraps around.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - Synchroniser flops, btn_stable, btn_stable_q, debounce counter, pulse counter, step_count, step_clk are all cleared to 0.
  - FSM goes to IDLE.
  - step_clk drops the moment reset is asserted, even in the middle of a pulse.
- Synchroniser: two flops, s1 <= btn_in, then s2 <= s1.
- Debounce:
  - If s2 == btn_stable, the counter clears to 0.
  - Otherwise, if the counter == DEBOUNCE_CYCLES-1, btn_stable takes s2 and the counter clears.
  - Otherwise the counter increments.
  - Any disagreement shorter than DEBOUNCE_CYCLES consecutive cycles leaves btn_stable unchanged.
- Edge detect: btn_stable_q is btn_stable delayed by one cycle; rise = btn_stable & ~btn_stable_q.
- FSM states are IDLE, PULSE and WAIT_REL:
  - IDLE: on rise & step_en, go to PULSE, load the pulse counter, and increment step_count (it wraps from all-ones to 0). On rise & ~step_en, the press is ignored and the FSM stays in IDLE.
  - PULSE: step_clk = 1 for exactly PULSE_CYCLES cycles, then go to WAIT_REL with step_clk = 0. Deasserting step_en or releasing the button during PULSE does not shorten the pulse.
  - WAIT_REL: go to IDLE on the first cycle that btn_stable == 0. A press that is still held never retriggers.
- Latency: counting the first out_clk rising edge that samples btn_in = 1 (and holds it steady) as edge 1:
  - btn_stable rises after edge DEBOUNCE_CYCLES+2.
  - step_clk rises after edge DEBOUNCE_CYCLES+3.
  - step_count updates at the same edge that step_clk rises.
- step_en rising while the button is already held gives no pulse, because a fresh rise is required.
- Button held through a reset: btn_stable restarts at 0, so after reset is released the held button is accepted as a new press. This gives one pulse at the normal latency; this behaviour is intended.
- step_clk is a flop output only, never combinational, so it is glitch-free.

Decomposition:
- Add `DEBOUNCE_MAX and `STEP_PULSE_CYCLES to define.v, next to `COUNTER_MAX. The FSM state encodings are local parameters.
- One sub-module is natural: btn_debounce, containing the synchroniser, the debounce counter and btn_stable. The FSM and counters stay in step_clk_gen.

Test Plan (DEBOUNCE_CYCLES=4, PULSE_CYCLES=3, CNT_W=2 unless noted):
- Clean press, btn_in=1 from edge 1, held for 20 cycles, step_en=1 -> btn_stable=1 after edge 6; step_clk=1 after edges 7, 8 and 9, and 0 after edge 10; step_count=1; step_busy stays high until btn_stable falls after release.
- Bouncing press: btn_in toggles every 2 cycles for 12 cycles, then stays at 1 -> exactly one 3-cycle pulse, starting 7 edges after the final steady 1; step_count=1.
- Glitch: btn_in=1 for 3 cycles, then 0 -> btn_stable never rises, step_clk stays 0, step_count=0.
- Gating: press with step_en=0, and raise step_en while the button is still held -> no pulse, step_count=0. Release and press again with step_en=1 -> one pulse, step_count=1.
- Wrap: 5 clean presses -> step_count goes 1, 2, 3, 0, 1, with exactly 5 pulses of 3 cycles each.
- Reset mid-pulse: assert reset during the second high cycle of step_clk -> step_clk=0, step_count=0 and step_busy=0 in the same cycle. With the button still held, release reset -> one new pulse starting 7 edges after the release, step_count=1.
